// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32 immediate decoder feeding a 2-entry in-order output buffer
//
// Purpose:
//   Decodes the immediate field of an RV32 base instruction word combinationally.
//   On each input transfer it writes the immediate, the format code and an illegal
//   flag into a 2-entry in-order buffer. The oldest buffered entry drives the outputs
//   directly from registers. The block also keeps a saturating count of accepted
//   instructions whose opcode has no immediate format.
//
// Parameters:
//   XLEN    - width of out_imm (32 or 64)
//   SEXT_EN - 1: sign-extend immediates, 0: zero-extend (legacy mode)
//   CNT_W   - width of illegal_cnt
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   in_instr is valid
//   in_ready    out  buffer can accept in_instr this cycle
//   in_instr    in   32-bit instruction word
//   out_valid   out  buffer holds at least one entry
//   out_ready   in   consumer takes the oldest entry this cycle
//   out_imm     out  decoded immediate of the oldest entry
//   out_fmt     out  format code (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J)
//   out_illegal out  oldest entry's opcode has no immediate format
//   illegal_cnt out  saturating count of accepted illegal instructions

module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int SEXT_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic SX = (SEXT_EN != 0);

  fmt_e            dec_fmt;
  logic [31:0]     raw32;
  logic [XLEN-1:0] dec_imm;

  // raw32 holds the immediate already extended to 32 bits; the fill bit is
  // gated by SX so zero-extension falls out of the same expressions.
  always_comb begin
    dec_fmt = FMT_NONE;
    raw32   = '0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw32   = {{20{SX & in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw32   = {{20{SX & in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw32   = {{19{SX & in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw32   = {{11{SX & in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Bit 31 of raw32 is the true sign for every format (U included), so the
  // upper half on a 64-bit datapath replicates it when sign-extending.
  generate
    if (XLEN > 32) begin : g_wide
      assign dec_imm = {{(XLEN-32){SX & raw32[31]}}, raw32};
    end else begin : g_narrow
      assign dec_imm = raw32;
    end
  endgenerate

  logic [XLEN-1:0] imm_q [2];
  logic [2:0]      fmt_q [2];
  logic            ill_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            in_fire;
  logic            out_fire;
  logic            dec_illegal;

  assign dec_illegal = (dec_fmt == FMT_NONE);
  assign in_ready    = ~rst & (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;

  assign out_imm     = imm_q[rd_ptr];
  assign out_fmt     = fmt_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q[0] <= '0;
      imm_q[1] <= '0;
      fmt_q[0] <= '0;
      fmt_q[1] <= '0;
      ill_q[0] <= 1'b0;
      ill_q[1] <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (in_fire) begin
        imm_q[wr_ptr] <= dec_imm;
        fmt_q[wr_ptr] <= dec_fmt;
        ill_q[wr_ptr] <= dec_illegal;
        wr_ptr        <= ~wr_ptr;
      end
      if (out_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({in_fire, out_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (in_fire && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  always #5 clk = ~clk;

  logic        r0, v0, ill0;  logic [31:0] imm0; logic [2:0] fmt0; logic [15:0] cnt0;
  logic        r1, v1, ill1;  logic [63:0] imm1; logic [2:0] fmt1; logic [15:0] cnt1;
  logic        r2, v2, ill2;  logic [31:0] imm2; logic [2:0] fmt2; logic [15:0] cnt2;
  logic        r3, v3, ill3;  logic [31:0] imm3; logic [2:0] fmt3; logic [1:0]  cnt3;

  imm_gen_pipe #(.XLEN(32), .SEXT_EN(1), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_instr(in_instr),
    .out_valid(v0), .out_ready(out_ready), .out_imm(imm0), .out_fmt(fmt0),
    .out_illegal(ill0), .illegal_cnt(cnt0));

  imm_gen_pipe #(.XLEN(64), .SEXT_EN(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_instr(in_instr),
    .out_valid(v1), .out_ready(out_ready), .out_imm(imm1), .out_fmt(fmt1),
    .out_illegal(ill1), .illegal_cnt(cnt1));

  imm_gen_pipe #(.XLEN(32), .SEXT_EN(0), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_instr(in_instr),
    .out_valid(v2), .out_ready(out_ready), .out_imm(imm2), .out_fmt(fmt2),
    .out_illegal(ill2), .illegal_cnt(cnt2));

  imm_gen_pipe #(.XLEN(32), .SEXT_EN(1), .CNT_W(2)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r3), .in_instr(in_instr),
    .out_valid(v3), .out_ready(out_ready), .out_imm(imm3), .out_fmt(fmt3),
    .out_illegal(ill3), .illegal_cnt(cnt3));

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] q[$];
  int unsigned mcnt  = 0;
  int unsigned mcnt2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      default:             return 0;
    endcase
  endfunction

  // Assemble the raw immediate as a number of a known bit width, then extend.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen, input bit sext);
    longint unsigned raw;
    int w;
    case (ref_fmt(i))
      1: begin raw = i[31:20]; w = 12; end
      2: begin raw = i[31:25] * 32 + i[11:7]; w = 12; end
      3: begin raw = i[31] * 4096 + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2; w = 13; end
      4: begin raw = i[31:12] * 4096; w = 32; end
      5: begin raw = i[31] * (1 << 20) + i[19:12] * (1 << 12) + i[20] * (1 << 11) + i[30:21] * 2; w = 21; end
      default: return 64'd0;
    endcase
    if (sext && raw[w-1]) raw = raw | ~((64'd1 << w) - 64'd1);
    if (xlen == 32) raw = raw & 64'hFFFF_FFFF;
    return raw;
  endfunction

  // Drive one cycle of stimulus, check every instance against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic step(input bit v, input logic [31:0] instr, input bit ordy);
    bit exp_rdy, exp_val, in_fire, out_fire;
    logic [31:0] h;
    logic [2:0] f;
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (q.size() < 2);
    exp_val = (q.size() > 0);
    chk("in_ready", {r0, r1, r2, r3}, {4{exp_rdy}});
    chk("out_valid", {v0, v1, v2, v3}, {4{exp_val}});
    if (exp_val) begin
      h = q[0];
      f = 3'(ref_fmt(h));
      chk("imm_x32", imm0, ref_imm(h, 32, 1));
      chk("imm_x64", imm1, ref_imm(h, 64, 1));
      chk("imm_zext", imm2, ref_imm(h, 32, 0));
      chk("fmt", {fmt0, fmt1, fmt2, fmt3}, {4{f}});
      chk("illegal", {ill0, ill1, ill2, ill3}, {4{f == 3'd0}});
    end
    chk("illegal_cnt", cnt0, mcnt);
    chk("illegal_cnt_w2", cnt3, mcnt2);
    in_fire  = v && exp_rdy;
    out_fire = ordy && exp_val;
    if (out_fire) void'(q.pop_front());
    if (in_fire) begin
      q.push_back(instr);
      if (ref_fmt(instr) == 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {v0, v1, v2, v3}, 4'b0000);
    chk("rst_in_ready", {r0, r1, r2, r3}, 4'b0000);
    chk("rst_cnt", {cnt0, cnt3}, 18'd0);
    chk("rst_imm", {imm0, imm1, imm2}, 128'd0);
    chk("rst_fmt_ill", {fmt0, ill0, fmt1, ill1}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mcnt  = 0;
    mcnt2 = 0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] immz;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t tbl[13];
  logic [6:0] ops[10];
  logic [31:0] hold_imm;
  logic [2:0]  hold_fmt;
  logic [31:0] rnd;

  initial begin
    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'h00000FFF, 3'd1, 1'b0};
    tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'h00000FFC, 3'd2, 1'b0};
    tbl[2]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 32'h12345000, 3'd4, 1'b0};
    tbl[3]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 32'h001FFFFE, 3'd5, 1'b0};
    tbl[4]  = '{32'h00000000, 32'h00000000, 64'h0000000000000000, 32'h00000000, 3'd0, 1'b1};
    tbl[5]  = '{32'h00000463, 32'h00000008, 64'h0000000000000008, 32'h00000008, 3'd3, 1'b0};
    tbl[6]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'h00001FFC, 3'd3, 1'b0};
    tbl[7]  = '{32'h00001017, 32'h00001000, 64'h0000000000001000, 32'h00001000, 3'd4, 1'b0};
    tbl[8]  = '{32'h01012083, 32'h00000010, 64'h0000000000000010, 32'h00000010, 3'd1, 1'b0};
    tbl[9]  = '{32'h000080E7, 32'h00000000, 64'h0000000000000000, 32'h00000000, 3'd1, 1'b0};
    tbl[10] = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 32'h00000000, 3'd0, 1'b1};
    tbl[11] = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, 32'h00000000, 3'd0, 1'b1};
    tbl[12] = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 1'b0};
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", {v0, v1, v2, v3}, 4'b0000);
    chk("init_cnt", {cnt0, cnt3}, 18'd0);
    chk("init_imm", {imm0, fmt0, ill0}, 36'd0);
    rst = 1'b0;

    // Table vectors: one entry at a time, checked the cycle after acceptance.
    for (int k = 0; k < 13; k++) begin
      step(1'b1, tbl[k].instr, 1'b0);
      chk("tbl_valid", v0, 1'b1);
      chk("tbl_imm32", imm0, tbl[k].imm32);
      chk("tbl_imm64", imm1, tbl[k].imm64);
      chk("tbl_immz", imm2, tbl[k].immz);
      chk("tbl_fmt", fmt0, tbl[k].fmt);
      chk("tbl_ill", ill0, tbl[k].ill);
      step(1'b0, 32'h0, 1'b1);
    end
    chk("tbl_illegal_cnt", cnt0, 16'd3);

    // Back-to-back flow with out_ready held high.
    step(1'b1, 32'hFE112E23, 1'b1);
    step(1'b1, 32'h123450B7, 1'b1);
    step(1'b1, 32'hFFFFF06F, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1);

    // Stall: third entry must wait while the buffered head stays stable.
    step(1'b1, 32'h00000463, 1'b0);
    step(1'b1, 32'h800000B7, 1'b0);
    hold_imm = imm0;
    hold_fmt = fmt0;
    step(1'b1, 32'h01012083, 1'b0);
    step(1'b1, 32'h01012083, 1'b0);
    chk("stall_in_ready", r0, 1'b0);
    chk("stall_hold_imm", imm0, 32'h00000008);
    chk("stall_hold_fmt", {hold_fmt, fmt0}, {3'd3, 3'd3});
    chk("stall_hold_same", imm0, hold_imm);
    step(1'b1, 32'h01012083, 1'b1);
    step(1'b1, 32'h01012083, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // Reset with two entries buffered and a nonzero illegal count.
    step(1'b1, 32'h00000000, 1'b0);
    step(1'b1, 32'hFFF00093, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b1);

    // Illegal counting and saturation of the narrow counter.
    step(1'b1, 32'h00000000, 1'b1);
    step(1'b1, 32'h00000000, 1'b1);
    chk("ill_cnt_two", cnt0, 16'd2);
    repeat (3) step(1'b1, 32'h00000000, 1'b1);
    chk("ill_cnt_five", cnt0, 16'd5);
    chk("ill_cnt_sat", cnt3, 2'd3);
    repeat (2) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom();
      step(($urandom() % 4) != 0, {rnd[31:7], ops[$urandom_range(0, 9)]}, ($urandom() % 3) != 0);
    end
    repeat (3) step(1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
